// File: rtl/cipher_pkg.sv
// Shared types for the cipher stream controller: FSM states, FIFO entry and shadow pipe layouts.
package cipher_pkg;

  localparam int CHAR_W  = 8;
  localparam int ENTRY_W = CHAR_W + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CHAR_W-1:0] data;
    logic              raw;
    logic              last;
  } entry_t;

  // Travels beside the core so the original byte and last tag line up with the core result.
  typedef struct packed {
    logic              valid;
    logic              last;
    logic [CHAR_W-1:0] data;
  } shadow_t;

endpackage

// File: rtl/cipher_out_fifo.sv
// Synchronous FIFO (power-of-two depth) with occupancy count; head is visible while not empty.
module cipher_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cipher_stream_ctrl.sv
// Frames a byte stream through cipher_core: seeds per message, steps once per char, buffers results.
// Optional statistics counters are built when CIPHER_STREAM_STATS_EN is defined.
module cipher_stream_ctrl
  import cipher_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CORE_LAT   = 1,
  parameter int MAX_LEN    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CHAR_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CHAR_W-1:0] m_data,
  output logic              m_raw,
  output logic              m_last,
  output logic              core_start,
  output logic              core_ce,
  output logic [CHAR_W-1:0] core_ch_in,
  input  logic [CHAR_W-1:0] core_ch_out,
  input  logic              core_valid_out,
  input  logic              core_in_table,
  output logic              busy,
  output logic              msg_done,
  output logic              trunc
`ifdef CIPHER_STREAM_STATS_EN
  ,
  output logic [15:0]       stat_chars,
  output logic [15:0]       stat_raw
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  // Both streams: a beat transfers on the rising edge where valid and ready are both high;
  // valid never waits on ready, and s_ready here is a function of s_valid and credit.
  state_t           state;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] used;
  logic [LEN_W-1:0] len_cnt;
  logic             discarding;
  logic             out_done;
  logic             step;
  logic             len_hit;
  logic             push;
  logic             pop;
  logic             pop_last;
  logic             fifo_empty;
  logic             core_hit;
  shadow_t          pipe [CORE_LAT];
  entry_t           push_entry;
  entry_t           head;

  always_comb begin
    used    = {1'b0, fifo_count} + {1'b0, inflight};
    s_ready = 1'b0;
    case (state)
      STREAM:  s_ready = s_valid && (used < SUM_W'(FIFO_DEPTH));
      DRAIN:   s_ready = s_valid && discarding;
      default: s_ready = 1'b0;
    endcase
  end

  assign step       = s_ready && (state == STREAM);
  assign core_ce    = step;
  assign core_ch_in = step ? s_data : '0;
  assign len_hit    = (len_cnt == LEN_W'(MAX_LEN - 1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: step, last: s_last || len_hit, data: s_data};
      for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // A table hit without core_valid_out breaks the core contract; fall back to the raw byte.
  assign core_hit   = core_in_table && core_valid_out;
  assign push       = pipe[CORE_LAT-1].valid;
  assign push_entry = '{data: core_hit ? core_ch_out : pipe[CORE_LAT-1].data,
                        raw:  !core_hit,
                        last: pipe[CORE_LAT-1].last};

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({step, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  cipher_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid  = !fifo_empty;
  assign m_data   = head.data;
  assign m_raw    = head.raw;
  assign m_last   = head.last;
  assign pop      = m_valid && m_ready;
  assign pop_last = pop && head.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_cnt    <= '0;
      discarding <= 1'b0;
      out_done   <= 1'b0;
      trunc      <= 1'b0;
      core_start <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      msg_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            state      <= SEED;
            core_start <= 1'b1;
          end
        end
        SEED: begin
          state      <= STREAM;
          trunc      <= 1'b0;
          len_cnt    <= '0;
          discarding <= 1'b0;
          out_done   <= 1'b0;
        end
        STREAM: begin
          if (step) begin
            len_cnt <= len_cnt + LEN_W'(1);
            if (s_last || len_hit) begin
              state      <= DRAIN;
              discarding <= len_hit && !s_last;
            end
          end
        end
        DRAIN: begin
          // Excess characters are swallowed here until the sender's own last flag.
          if (s_ready) begin
            trunc <= 1'b1;
            if (s_last) discarding <= 1'b0;
          end
          if (pop_last) begin
            out_done <= 1'b1;
            msg_done <= 1'b1;
          end
          if ((out_done || pop_last) && (!discarding || (s_ready && s_last)))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CIPHER_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_chars <= '0;
      stat_raw   <= '0;
    end else if (push) begin
      if (stat_chars != 16'hFFFF) stat_chars <= stat_chars + 16'd1;
      if (push_entry.raw && (stat_raw != 16'hFFFF)) stat_raw <= stat_raw + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cipher_stream_ctrl.sv
// Bench for cipher_stream_ctrl with a behavioural cipher_core and a message-level reference model.
module tb_cipher_stream_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int CORE_LAT   = 1;
  localparam int MAX_LEN    = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_valid, m_ready = 1'b1, m_raw, m_last;
  logic [7:0] m_data;
  logic       core_start, core_ce, core_valid_out = 1'b0, core_in_table = 1'b0;
  logic [7:0] core_ch_in, core_ch_out = 8'h00;
  logic       busy, msg_done, trunc;
`ifdef CIPHER_STREAM_STATS_EN
  logic [15:0] stat_chars, stat_raw;
`endif

  cipher_stream_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CORE_LAT   (CORE_LAT),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_raw          (m_raw),
    .m_last         (m_last),
    .core_start     (core_start),
    .core_ce        (core_ce),
    .core_ch_in     (core_ch_in),
    .core_ch_out    (core_ch_out),
    .core_valid_out (core_valid_out),
    .core_in_table  (core_in_table),
    .busy           (busy),
    .msg_done       (msg_done),
    .trunc          (trunc)
`ifdef CIPHER_STREAM_STATS_EN
    ,
    .stat_chars     (stat_chars),
    .stat_raw       (stat_raw)
`endif
  );

  // ---------------- cipher table and golden core ----------------
  function automatic int tbl_idx(input logic [7:0] c);
    if (c >= "A" && c <= "Z") return int'(c) - 65;
    if (c >= "a" && c <= "z") return int'(c) - 97 + 26;
    if (c >= "0" && c <= "9") return int'(c) - 48 + 52;
    return -1;
  endfunction

  function automatic logic [7:0] tbl_chr(input int i);
    if (i < 26) return 8'(65 + i);
    if (i < 52) return 8'(97 + i - 26);
    return 8'(48 + i - 52);
  endfunction

  // Keystream position k = number of steps since the last seed reload.
  function automatic logic [7:0] enc(input logic [7:0] c, input int k);
    return tbl_chr((tbl_idx(c) + 7 * k + 3) % 62);
  endfunction

  int key = 0;
  bit glitch = 1'b0;
  always @(posedge clk) begin
    if (core_start) key <= 0;
    if (core_ce) begin
      core_ch_out    <= enc(core_ch_in, key);
      core_in_table  <= (tbl_idx(core_ch_in) >= 0);
      core_valid_out <= !glitch;
      key            <= key + 1;
    end else begin
      core_ch_out    <= 8'h00;
      core_in_table  <= 1'b0;
      core_valid_out <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];
  logic [7:0] out_log[$];
  logic [7:0] ref_log[$];
  logic [7:0] msg_buf[512];
  int start_cnt = 0, ce_cnt = 0, md_cnt = 0, ce_early = 0, md_exp = 0;
  int exp_chars = 0, exp_raw = 0;
  bit started = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      started = 1'b0;
    end else begin
      if (core_start) begin start_cnt++; started = 1'b1; end
      if (core_ce) begin ce_cnt++; if (!started) ce_early++; end
      if (msg_done) begin md_cnt++; started = 1'b0; end
      if (m_valid && m_ready) begin
        check("sb_has_exp", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("out_entry", {m_data, m_raw, m_last}, exp_q.pop_front());
          out_log.push_back(m_data);
        end
      end
    end
  end

  // Reference: char j of a message is enciphered at keystream position j; only the first
  // MAX_LEN chars produce output, the final one tagged last.
  task automatic expect_msg(input int n, input bit force_raw);
    int nout = (n < MAX_LEN) ? n : MAX_LEN;
    for (int j = 0; j < nout; j++) begin
      logic [7:0] c = msg_buf[j];
      bit hit = (tbl_idx(c) >= 0) && !force_raw;
      exp_q.push_back({hit ? enc(c, j) : c, !hit, j == nout - 1});
      exp_chars++;
      if (!hit) exp_raw++;
    end
    md_exp++;
  endtask

  // ---------------- drivers ----------------
  int stall_cnt = 0;
  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        m_ready = 1'b0;
        stall_cnt--;
      end else begin
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic set_str(input string s);
    for (int i = 0; i < s.len(); i++) msg_buf[i] = s[i];
  endtask

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 9))
      7:       return 8'h23;
      8:       return 8'h26;
      9:       return 8'h20;
      default: return tbl_chr($urandom_range(0, 61));
    endcase
  endfunction

  task automatic send_msg(input int n, input int stop_after, input bit gaps);
    for (int i = 0; i < n && i < stop_after; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_data  = msg_buf[i];
      s_last  = (i == n - 1);
      begin
        int w = 0;
        @(negedge clk);
        while (!s_ready && w < 300) begin @(negedge clk); w++; end
      end
      check("accept", s_ready, 1);
      if (!s_ready) break;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int w = 0;
    while (md_cnt < md_exp && w < 5000) begin @(negedge clk); w++; end
    check("msg_done_cnt", md_cnt, md_exp);
    w = 0;
    while (busy && w < 2000) begin @(negedge clk); w++; end
    check("idle_after", busy, 0);
    repeat (2) @(negedge clk);
    check("drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0, c0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {s_ready, m_valid, busy, core_start, core_ce, msg_done, trunc}, 0);
    check("rst_ch_in", core_ch_in, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic message with one raw character.
    set_str("Pa#1");
    s0 = start_cnt; c0 = ce_cnt;
    out_log.delete();
    expect_msg(4, 0);
    send_msg(4, 4, 0);
    wait_done();
    check("pa_starts", start_cnt - s0, 1);
    check("pa_steps", ce_cnt - c0, 4);
    check("pa_trunc", trunc, 0);
    check("pa_raw_byte", out_log.size() > 2 ? out_log[2] : 8'h00, 8'h23);
    ref_log = out_log;

    // Same message under a 20-cycle output stall.
    out_log.delete();
    stall_cnt = 20;
    expect_msg(4, 0);
    send_msg(4, 4, 0);
    wait_done();
    check("stall_len", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size() && i < ref_log.size(); i++)
      check("stall_same_ct", out_log[i], ref_log[i]);

    // Longer message under stall: steps stop at FIFO_DEPTH credit.
    for (int i = 0; i < 8; i++) msg_buf[i] = rand_char();
    stall_cnt = 30;
    c0 = ce_cnt;
    expect_msg(8, 0);
    fork
      send_msg(8, 8, 0);
      begin
        repeat (15) @(posedge clk);
        #2;
        check("stall_steps", ce_cnt - c0, FIFO_DEPTH);
        check("stall_s_ready", s_ready, 0);
      end
    join
    wait_done();

    // Back-to-back identical messages: seed reload gives identical ciphertext.
    out_log.delete();
    s0 = start_cnt;
    set_str("ab");
    expect_msg(2, 0);
    send_msg(2, 2, 0);
    expect_msg(2, 0);
    send_msg(2, 2, 0);
    wait_done();
    check("b2b_starts", start_cnt - s0, 2);
    check("b2b_len", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("b2b_ct0", out_log[2], out_log[0]);
      check("b2b_ct1", out_log[3], out_log[1]);
    end

    // Truncation: 300 chars in, 255 out, rest accepted and dropped.
    for (int i = 0; i < 300; i++) msg_buf[i] = rand_char();
    c0 = ce_cnt;
    rand_ready = 1'b1;
    expect_msg(300, 0);
    send_msg(300, 300, 1);
    wait_done();
    rand_ready = 1'b0;
    check("trunc_steps", ce_cnt - c0, MAX_LEN);
    check("trunc_flag", trunc, 1);

    // Reset mid-message.
    set_str("Paula");
    stall_cnt = 50;
    s0 = md_cnt;
    send_msg(5, 2, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", md_cnt - s0, 0);
    check("rst_mid_trunc", trunc, 0);
    exp_chars = 0;
    exp_raw   = 0;
    stall_cnt = 0;
    @(posedge clk); #1;

    set_str("Te");
    s0 = start_cnt;
    expect_msg(2, 0);
    send_msg(2, 2, 0);
    wait_done();
    check("te_starts", start_cnt - s0, 1);

    // Core reports in-table without valid_out: results must come out raw.
    set_str("Ab");
    glitch = 1'b1;
    expect_msg(2, 1);
    send_msg(2, 2, 0);
    wait_done();
    glitch = 1'b0;

    // Randomized messages with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int m = 0; m < 20; m++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) msg_buf[i] = rand_char();
      expect_msg(n, 0);
      send_msg(n, n, 1);
      if ($urandom_range(0, 1) == 1) wait_done();
    end
    wait_done();
    rand_ready = 1'b0;

    set_str("P&0");
    expect_msg(3, 0);
    send_msg(3, 3, 0);
    wait_done();
`ifdef CIPHER_STREAM_STATS_EN
    check("stat_chars", stat_chars, exp_chars);
    check("stat_raw", stat_raw, exp_raw);
`endif

    check("ce_before_start", ce_early, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cipher_stream_ctrl.md
Name: cipher_stream_ctrl

Overview:
- Sequences one `cipher_core` instance over framed byte messages.
- Accepts a valid/ready character stream with a last flag and pulses the core's seed reload at each message start.
- Presents one character per enabled core step, buffers results in an output FIFO, and emits a valid/ready ciphertext stream with a raw (not-in-table) marker.
- Sits between the UART/host byte interface and `cipher_core`.

Parameters:
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥ CORE_LAT+1).
- CORE_LAT, 1, cycles from `core_ce`-qualified input to `core_valid_out`/`core_ch_out` valid.
- MAX_LEN, 255, maximum characters per message; excess characters are truncated.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_valid  in  1  input character valid
- s_ready  out  1  controller accepts `s_data` this cycle
- s_data  in  8  plaintext character
- s_last  in  1  final character of message
- m_valid  out  1  output character valid
- m_ready  in  1  downstream accepts
- m_data  out  8  ciphertext (or raw) character
- m_raw  out  1  character was not in table, passed unchanged
- m_last  out  1  final character of message
- core_start  out  1  one-cycle seed reload pulse to core `start`
- core_ce  out  1  core keystream step enable (one step per presented character)
- core_ch_in  out  8  character to core `ch_in`
- core_ch_out  in  8  core result
- core_valid_out  in  1  core result valid
- core_in_table  in  1  core reports character in table
- busy  out  1  FSM not IDLE
- msg_done  out  1  one-cycle pulse when last output of a message is accepted
- trunc  out  1  sticky per message; set when MAX_LEN exceeded, cleared at next SEED

Behaviour:
- Reset:
  - FSM enters IDLE; FIFO is emptied; in-flight count and length counter clear.
  - All outputs are 0, except `core_ch_in`, which holds 8'h00.
- FSM states and transitions:
  - IDLE: `s_ready`=0. On `s_valid`=1, go to SEED.
  - SEED: assert `core_start`=1 for exactly one cycle, clear `trunc`, go to STREAM. No character is consumed in this cycle.
  - STREAM: `s_ready` = `s_valid` AND credit>0, where credit = FIFO_DEPTH − fifo_count − inflight.
    - On handshake: `core_ce`=1 and `core_ch_in`=`s_data`; inflight increments; the `s_last` tag and the raw-path byte go into a CORE_LAT-deep shadow pipe.
    - On handshake with `s_last`=1, or when the length counter reaches MAX_LEN: go to DRAIN.
    - Characters after MAX_LEN are accepted and dropped until `s_last` arrives (`trunc`=1, `core_ce`=0 for them).
    - The MAX_LEN-th character is forced tagged last.
  - DRAIN: `s_ready`=0 (unless still discarding truncated input). When inflight=0, the FIFO is empty and the final output handshake occurs, pulse `msg_done` and go to IDLE.
- `core_ce`=0 on every cycle without an input handshake; the keystream never advances on idle cycles.
- Result capture, CORE_LAT cycles after each step:
  - Push {data, raw, last} into the FIFO; inflight decrements.
  - data = `core_ch_out` if `core_in_table`=1, else the shadow-piped original byte; raw = NOT `core_in_table`.
  - If `core_valid_out`=0 with `core_in_table`=1, the core violated its contract; treat the result as raw.
- Output:
  - `m_valid` = FIFO not empty; `m_data`/`m_raw`/`m_last` come from the FIFO head.
  - Pop on `m_valid` & `m_ready`.
  - Push and pop in the same cycle keep the count unchanged.
- Credit rule guarantees no FIFO overflow. Inflight plus count never exceeds FIFO_DEPTH.
- Back-to-back messages: the IDLE→SEED transition may occur in the same cycle as `msg_done`.
- `rst` mid-message: the message is lost, state clears next cycle, and no `msg_done` is emitted.

Optional Feature:
- CIPHER_STREAM_STATS_EN defined: adds outputs `stat_chars` [15:0] (characters pushed to FIFO, saturating) and `stat_raw` [15:0] (raw characters, saturating), both cleared by `rst` only.
- Undefined: the ports are absent and no counters are built.

Decomposition:
- Package `cipher_pkg`: FSM state encoding (IDLE, SEED, STREAM, DRAIN), FIFO entry width constant (10 bits: data, raw, last), character width 8.
- One sub-module: `cipher_out_fifo`, a synchronous FIFO with parameterised depth and count output.

Test Plan:
- "Pa#1" with `s_last` on '1', `m_ready`=1: exactly one `core_start` before the first `core_ce`; 4 outputs in order; '#' → `m_data`=8'h23 with `m_raw`=1; the other three match the golden core model; `m_last` is set only on the 4th output; `msg_done` pulses once.
- Same 4-character message with `m_ready`=0 for 20 cycles: at most FIFO_DEPTH steps taken; `s_ready` drops; no output lost or duplicated after release; the ciphertext equals the no-stall run.
- Two messages back to back ("ab", "ab"): two `core_start` pulses; both messages produce identical ciphertext (seed reload verified).
- Message of 300 characters with MAX_LEN=255: 255 outputs, `m_last` on the 255th, `trunc`=1; the remaining 45 inputs are accepted and dropped.
- `rst` asserted after 2 of 5 characters of "Paula": next cycle `m_valid`=0, `busy`=0, no `msg_done`; the following message "Te" starts with a fresh `core_start`.
- With CIPHER_STREAM_STATS_EN, message "P&0": `stat_chars`=3 and `stat_raw` equals the model's not-in-table count.
